// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, field widths and address slicing for the direct-mapped data cache
package dcache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;

    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;
    localparam int ADDR_W     = TAG_LSB + TAG_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/dirty/tag/data storage with combinational lookup and synchronous update
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int DATA_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    output logic                line_valid,
    output logic                line_dirty,
    output logic [TAG_W-1:0]    line_tag,
    output logic [DATA_W-1:0]   line_data,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [7:0]          byte_data,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [DATA_W-1:0]   fill_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES];

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (byte_we) begin
            data_q[index][{byte_offset, 3'b000} +: 8] <= byte_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - write-back, write-allocate direct-mapped data cache controller (optional DCACHE_STATS_EN counters)
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          address,
    input  logic [7:0]                 writedata,
    output logic [7:0]                 readdata,
    output logic                       busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [MEM_ADDR_W-1:0]      mem_address,
    output logic [BLOCK_BYTES*8-1:0]   mem_writedata,
    input  logic [BLOCK_BYTES*8-1:0]   mem_readdata,
    input  logic                       mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                hit_count,
    output logic [15:0]                miss_count
`endif
);

    localparam int DATA_W = BLOCK_BYTES * 8;

    state_t state, next_state;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                request;
    logic                hit;
    logic                fill_en;
    logic                line_valid;
    logic                line_dirty;
    logic [TAG_W-1:0]    line_tag;
    logic [DATA_W-1:0]   line_data;

    assign req_tag    = address[TAG_LSB +: TAG_W];
    assign req_index  = address[INDEX_LSB +: INDEX_W];
    assign req_offset = address[OFFSET_LSB +: OFFSET_W];

    // Simultaneous read and write is treated as no request at all.
    assign request  = read ^ write;
    assign hit      = (state == ST_IDLE) && line_valid && (line_tag == req_tag);
    assign busywait = request && !hit;
    assign readdata = (hit && read && !write) ? line_data[{req_offset, 3'b000} +: 8] : 8'h00;

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .DATA_W    (DATA_W)
    ) u_lines (
        .clock       (clock),
        .reset       (reset),
        .index       (req_index),
        .line_valid  (line_valid),
        .line_dirty  (line_dirty),
        .line_tag    (line_tag),
        .line_data   (line_data),
        .byte_we     (hit && write && !read),
        .byte_offset (req_offset),
        .byte_data   (writedata),
        .fill_en     (fill_en),
        .fill_tag    (req_tag),
        .fill_data   (mem_readdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        fill_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (request && !hit) begin
                    next_state = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, req_index};
                mem_writedata = line_data;
                if (!mem_busywait) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_read    = 1'b1;
                mem_address = {req_tag, req_index};
                if (!mem_busywait) begin
                    fill_en    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    // The cycle right after a fill completes the original missed request; it is not a new hit.
    logic just_filled;

    always_ff @(posedge clock) begin
        if (reset) begin
            just_filled <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            just_filled <= fill_en;
            if (request && hit && !just_filled && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (state == ST_IDLE && request && !hit && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller
module tb_dcache_controller;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    dcache_controller #(
        .NUM_LINES   (8),
        .BLOCK_BYTES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset        = 1'b1;
        read         = 1'b0;
        write        = 1'b0;
        address      = 8'h00;
        writedata    = 8'h00;
        mem_readdata = 32'h0;
        mem_busywait = 1'b0;
        tick();
        tick();
        check("rst_busywait", busywait, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_readdata", readdata, 0);
        reset = 1'b0;

        // cold read 0x25: tag 1, index 1 -> block address 6'h09
        read         = 1'b1;
        address      = 8'h25;
        mem_busywait = 1'b1;
        mem_readdata = 32'h44332211;
        #1;
        check("cold_busywait", busywait, 1);
        check("cold_idle_no_read", mem_read, 0);
        tick();
        check("fetch_mem_read", mem_read, 1);
        check("fetch_mem_write", mem_write, 0);
        check("fetch_mem_address", mem_address, 6'h09);
        check("fetch_busywait", busywait, 1);
        tick();
        check("fetch_stall_mem_read", mem_read, 1);
        mem_busywait = 1'b0;
        tick();
        check("fill_mem_read", mem_read, 0);
        check("fill_busywait", busywait, 0);
        check("fill_readdata", readdata, 8'h22);

        address = 8'h24;
        #1;
        check("hit_readdata", readdata, 8'h11);
        check("hit_busywait", busywait, 0);
        check("hit_mem_read", mem_read, 0);
        check("hit_mem_write", mem_write, 0);

        read      = 1'b0;
        write     = 1'b1;
        writedata = 8'hAA;
        #1;
        check("whit_busywait", busywait, 0);
        tick();
        write = 1'b0;
        read  = 1'b1;
        #1;
        check("whit_readback", readdata, 8'hAA);

        // 0xE4: tag 7 on index 1 evicts the dirty tag-1 line
        address      = 8'hE4;
        mem_readdata = 32'h87654321;
        #1;
        check("evict_busywait", busywait, 1);
        tick();
        check("wb_mem_write", mem_write, 1);
        check("wb_mem_read", mem_read, 0);
        check("wb_mem_address", mem_address, 6'h09);
        check("wb_mem_writedata", mem_writedata, 32'h443322AA);
        tick();
        check("wb2f_mem_write", mem_write, 0);
        check("wb2f_mem_read", mem_read, 1);
        check("wb2f_mem_address", mem_address, 6'h39);
        tick();
        check("evict_fill_mem_read", mem_read, 0);
        check("evict_fill_busywait", busywait, 0);
        check("evict_fill_readdata", readdata, 8'h21);

        read      = 1'b1;
        write     = 1'b1;
        address   = 8'h10;
        writedata = 8'h55;
        #1;
        check("both_busywait", busywait, 0);
        check("both_mem_read", mem_read, 0);
        check("both_mem_write", mem_write, 0);
        tick();
        check("both_after_mem_read", mem_read, 0);
        check("both_after_mem_write", mem_write, 0);
        address = 8'hE4;
        tick();
        write = 1'b0;
        #1;
        check("both_no_write", readdata, 8'h21);

        // 0x25 again: tag-7 line is clean, so straight to FETCH; reset it mid-fetch
        address      = 8'h25;
        mem_busywait = 1'b1;
        mem_readdata = 32'h44332211;
        #1;
        check("rf_busywait", busywait, 1);
        tick();
        check("rf_mem_read", mem_read, 1);
        check("rf_mem_address", mem_address, 6'h09);
        reset = 1'b1;
        tick();
        check("rf_reset_mem_read", mem_read, 0);
        check("rf_reset_mem_write", mem_write, 0);
        check("rf_reset_busywait", busywait, 1);
        reset        = 1'b0;
        mem_busywait = 1'b0;
        #1;
        check("rf_remiss_busywait", busywait, 1);
        tick();
        check("rf_refetch_mem_read", mem_read, 1);
        check("rf_refetch_mem_write", mem_write, 0);
        tick();
        check("rf_refill_readdata", readdata, 8'h22);
        check("rf_refill_busywait", busywait, 0);
        address = 8'hE4;
        #1;
        check("rf_cleared_busywait", busywait, 1);
        read = 1'b0;
        #1;
        check("idle_busywait", busywait, 0);
        tick();

`ifdef DCACHE_STATS_EN
        reset = 1'b1;
        tick();
        check("stats_rst_hit", hit_count, 0);
        check("stats_rst_miss", miss_count, 0);
        reset        = 1'b0;
        read         = 1'b1;
        address      = 8'h25;
        mem_busywait = 1'b0;
        mem_readdata = 32'h44332211;
        tick();
        tick();
        tick();
        address = 8'h24;
        tick();
        address = 8'h25;
        tick();
        read = 1'b0;
        tick();
        check("stats_miss", miss_count, 1);
        check("stats_hit", hit_count, 2);
        reset = 1'b1;
        tick();
        check("stats_clr_hit", hit_count, 0);
        check("stats_clr_miss", miss_count, 0);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
